// File: rtl/mem_issue_queue.sv
// rtl/mem_issue_queue.sv - in-order memory micro-op FIFO with cache steering and merged writeback
//
// Buffers up to DEPTH memory ops, computes each op's virtual address at enqueue,
// and presents the head op to either the DCache port or the ICache-cacop port.
// DCache and ICache responses are merged into one registered writeback port.
//
// Ports:
//   clk, a_rst          clock, asynchronous active-high reset
//   flush_i             synchronous pipeline flush
//   exe_*               enqueue side (valid/ready handshake, operands, op info)
//   dc_req_*            DCache request (valid/ready), head-of-queue fields
//   ic_req_*            ICache cacop request (valid/ready), head-of-queue fields
//   dc_busy_i/ic_busy_i cache has an op in flight
//   dc_rsp_*, ic_rsp_*  cache responses (valid/ready)
//   wb_*                registered writeback (valid/ready)
//   count_o             FIFO occupancy
module mem_issue_queue #(
  parameter int DATA_W = 32,
  parameter int ROB_W  = 6,
  parameter int PREG_W = 6,
  parameter int CODE_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   a_rst,
  input  logic                   flush_i,
  input  logic                   exe_valid_i,
  output logic                   exe_ready_o,
  input  logic [DATA_W-1:0]      exe_src0_i,
  input  logic [DATA_W-1:0]      exe_src1_i,
  input  logic [DATA_W-1:0]      exe_imm_i,
  input  logic [ROB_W-1:0]       exe_rob_idx_i,
  input  logic [PREG_W-1:0]      exe_pdest_i,
  input  logic                   exe_pdest_valid_i,
  input  logic [1:0]             exe_mem_op_i,
  input  logic [CODE_W-1:0]      exe_code_i,
  output logic                   dc_req_valid_o,
  input  logic                   dc_req_ready_i,
  output logic [DATA_W-1:0]      dc_req_vaddr_o,
  output logic [DATA_W-1:0]      dc_req_wdata_o,
  output logic [ROB_W-1:0]       dc_req_rob_idx_o,
  output logic [PREG_W-1:0]      dc_req_pdest_o,
  output logic                   dc_req_pdest_valid_o,
  output logic [1:0]             dc_req_mem_op_o,
  output logic [CODE_W-1:0]      dc_req_code_o,
  output logic                   ic_req_valid_o,
  input  logic                   ic_req_ready_i,
  output logic [DATA_W-1:0]      ic_req_vaddr_o,
  output logic [ROB_W-1:0]       ic_req_rob_idx_o,
  output logic [1:0]             ic_req_mode_o,
  input  logic                   dc_busy_i,
  input  logic                   ic_busy_i,
  input  logic                   dc_rsp_valid_i,
  output logic                   dc_rsp_ready_o,
  input  logic [DATA_W-1:0]      dc_rsp_rdata_i,
  input  logic [ROB_W-1:0]       dc_rsp_rob_idx_i,
  input  logic [PREG_W-1:0]      dc_rsp_pdest_i,
  input  logic                   dc_rsp_we_i,
  input  logic                   ic_rsp_valid_i,
  output logic                   ic_rsp_ready_o,
  input  logic [ROB_W-1:0]       ic_rsp_rob_idx_i,
  output logic                   wb_valid_o,
  input  logic                   wb_ready_i,
  output logic [ROB_W-1:0]       wb_rob_idx_o,
  output logic [PREG_W-1:0]      wb_pdest_o,
  output logic                   wb_we_o,
  output logic [DATA_W-1:0]      wb_wdata_o,
  output logic                   wb_icacop_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // FIFO storage; contents need no reset because pointers/count gate every use
  logic [DATA_W-1:0] r_vaddr    [DEPTH];
  logic [DATA_W-1:0] r_wdata    [DEPTH];
  logic [ROB_W-1:0]  r_rob      [DEPTH];
  logic [PREG_W-1:0] r_pdest    [DEPTH];
  logic              r_pdest_v  [DEPTH];
  logic [1:0]        r_mem_op   [DEPTH];
  logic [CODE_W-1:0] r_code     [DEPTH];
  logic              r_icacop   [DEPTH];

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_exe_icacop;
  logic [DATA_W-1:0] w_exe_offset;
  logic [DATA_W-1:0] w_exe_vaddr;
  logic              w_enq;
  logic              w_deq;
  logic              w_empty;
  logic              w_head_ic;
  logic              w_load_en;
  logic              w_ic_fire;
  logic              w_dc_fire;

  logic              r_wb_valid;
  logic [ROB_W-1:0]  r_wb_rob;
  logic [PREG_W-1:0] r_wb_pdest;
  logic              r_wb_we;
  logic [DATA_W-1:0] r_wb_wdata;
  logic              r_wb_icacop;

  // ICache cacop ops use a word-scaled offset; everything else is byte offset
  assign w_exe_icacop = (exe_mem_op_i == 2'd2) && (exe_code_i[1:0] == 2'b00);
  assign w_exe_offset = w_exe_icacop ? {exe_imm_i[DATA_W-3:0], 2'b00} : exe_imm_i;
  assign w_exe_vaddr  = exe_src0_i + w_exe_offset;

  assign exe_ready_o = (r_count < CNT_W'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_enq       = exe_valid_i & exe_ready_o & ~flush_i;

  // Head steering: the two cache ports are mutually exclusive per head op,
  // and each waits for the other cache to drain so ordering is preserved.
  assign w_head_ic      = r_icacop[r_rd_ptr];
  assign ic_req_valid_o = ~w_empty & w_head_ic & ~dc_busy_i;
  assign dc_req_valid_o = ~w_empty & ~w_head_ic & ~ic_busy_i;
  assign w_deq          = (dc_req_valid_o & dc_req_ready_i) | (ic_req_valid_o & ic_req_ready_i);

  assign dc_req_vaddr_o       = r_vaddr[r_rd_ptr];
  assign dc_req_wdata_o       = r_wdata[r_rd_ptr];
  assign dc_req_rob_idx_o     = r_rob[r_rd_ptr];
  assign dc_req_pdest_o       = r_pdest[r_rd_ptr];
  assign dc_req_pdest_valid_o = r_pdest_v[r_rd_ptr];
  assign dc_req_mem_op_o      = r_mem_op[r_rd_ptr];
  assign dc_req_code_o        = r_code[r_rd_ptr];
  assign ic_req_vaddr_o       = r_vaddr[r_rd_ptr];
  assign ic_req_rob_idx_o     = r_rob[r_rd_ptr];
  assign ic_req_mode_o        = r_code[r_rd_ptr][4:3];

  assign count_o = r_count;

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_vaddr[r_wr_ptr]   <= w_exe_vaddr;
      r_wdata[r_wr_ptr]   <= exe_src1_i;
      r_rob[r_wr_ptr]     <= exe_rob_idx_i;
      r_pdest[r_wr_ptr]   <= exe_pdest_i;
      r_pdest_v[r_wr_ptr] <= exe_pdest_valid_i;
      r_mem_op[r_wr_ptr]  <= exe_mem_op_i;
      r_code[r_wr_ptr]    <= exe_code_i;
      r_icacop[r_wr_ptr]  <= w_exe_icacop;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Writeback register: ICache response wins when both arrive together
  assign w_load_en      = ~r_wb_valid | wb_ready_i;
  assign ic_rsp_ready_o = w_load_en & ~flush_i;
  assign dc_rsp_ready_o = w_load_en & ~ic_rsp_valid_i & ~flush_i;
  assign w_ic_fire      = ic_rsp_valid_i & ic_rsp_ready_o;
  assign w_dc_fire      = dc_rsp_valid_i & dc_rsp_ready_o;

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      r_wb_valid  <= 1'b0;
      r_wb_rob    <= '0;
      r_wb_pdest  <= '0;
      r_wb_we     <= 1'b0;
      r_wb_wdata  <= '0;
      r_wb_icacop <= 1'b0;
    end else if (flush_i) begin
      r_wb_valid <= 1'b0;
    end else if (w_ic_fire) begin
      r_wb_valid  <= 1'b1;
      r_wb_rob    <= ic_rsp_rob_idx_i;
      r_wb_pdest  <= '0;
      r_wb_we     <= 1'b0;
      r_wb_wdata  <= '0;
      r_wb_icacop <= 1'b1;
    end else if (w_dc_fire) begin
      r_wb_valid  <= 1'b1;
      r_wb_rob    <= dc_rsp_rob_idx_i;
      r_wb_pdest  <= dc_rsp_pdest_i;
      r_wb_we     <= dc_rsp_we_i;
      r_wb_wdata  <= dc_rsp_rdata_i;
      r_wb_icacop <= 1'b0;
    end else if (wb_ready_i) begin
      r_wb_valid <= 1'b0;
    end
  end

  assign wb_valid_o   = r_wb_valid;
  assign wb_rob_idx_o = r_wb_rob;
  assign wb_pdest_o   = r_wb_pdest;
  assign wb_we_o      = r_wb_we;
  assign wb_wdata_o   = r_wb_wdata;
  assign wb_icacop_o  = r_wb_icacop;

endmodule

// File: doc/mem_issue_queue.md
Name: mem_issue_queue

Overview:
- Parametrised successor to the single-entry memory execute stage. Buffers up to DEPTH memory micro-ops from the issue/execute side in a FIFO and computes the virtual address. Steers each op in order to the DCache port or the ICache-cacop port.
- Merges both response streams into one registered writeback port with explicit arbitration. Sits between the memory issue queue and the commit/writeback bus.

Parameters:
- DATA_W 32: data/address width.
- ROB_W 6: ROB index width.
- PREG_W 6: physical register index width.
- CODE_W 5: cacop/barrier code width.
- DEPTH 4: FIFO entries; power of two, >=2.

Ports:
- clk input 1: clock.
- a_rst input 1: asynchronous active-high reset.
- flush_i input 1: pipeline flush.
- exe_valid_i/exe_ready_o in/out 1: enqueue handshake.
- exe_src0_i, exe_src1_i, exe_imm_i input DATA_W: base, store data, offset.
- exe_rob_idx_i input ROB_W; exe_pdest_i input PREG_W; exe_pdest_valid_i input 1.
- exe_mem_op_i input 2: 0 load, 1 store, 2 cacop, 3 preld.
- exe_code_i input CODE_W: cacop code.
- dc_req_valid_o/dc_req_ready_i out/in 1: DCache request handshake.
- dc_req_vaddr_o, dc_req_wdata_o output DATA_W.
- dc_req_rob_idx_o output ROB_W; dc_req_pdest_o output PREG_W; dc_req_pdest_valid_o output 1.
- dc_req_mem_op_o output 2; dc_req_code_o output CODE_W.
- ic_req_valid_o/ic_req_ready_i out/in 1: ICache cacop request handshake.
- ic_req_vaddr_o output DATA_W; ic_req_rob_idx_o output ROB_W; ic_req_mode_o output 2.
- dc_busy_i, ic_busy_i input 1: cache has an op in flight.
- dc_rsp_valid_i/dc_rsp_ready_o in/out 1: DCache response handshake.
- dc_rsp_rdata_i input DATA_W; dc_rsp_rob_idx_i input ROB_W; dc_rsp_pdest_i input PREG_W; dc_rsp_we_i input 1.
- ic_rsp_valid_i/ic_rsp_ready_o in/out 1: ICache response handshake.
- ic_rsp_rob_idx_i input ROB_W.
- wb_valid_o/wb_ready_i out/in 1: writeback handshake.
- wb_rob_idx_o output ROB_W; wb_pdest_o output PREG_W; wb_we_o output 1; wb_wdata_o output DATA_W; wb_icacop_o output 1.
- count_o output $clog2(DEPTH)+1: FIFO occupancy.

Behaviour:
- Reset (a_rst high, async): FIFO empty, pointers 0, count_o=0, wb_valid_o=0, all wb_* data outputs 0. exe_ready_o=1 one cycle after deassertion.
- Enqueue: exe_ready_o = (count<DEPTH). Entry written on exe_valid_i&exe_ready_o.
- Entry vaddr stored at enqueue:
  - icacop (mem_op==2 && code[1:0]==0): src0+(imm<<2).
  - All other ops: src0+imm.
  - Sum is mod 2^DATA_W.
- Head steering, combinational from head entry; strictly in order, never bypasses head.
  - ic_req_valid_o = !empty & head_is_icacop & !dc_busy_i.
  - dc_req_valid_o = !empty & !head_is_icacop & !ic_busy_i.
  - ic_req_mode_o = code[4:3]. Request fields are held stable while valid&!ready.
- Dequeue on (dc_req_valid_o&dc_req_ready_i) | (ic_req_valid_o&ic_req_ready_i). Simultaneous enqueue+dequeue when full is disallowed (ready=0). When not full, count unchanged. Pointers wrap at DEPTH.
- Writeback register (1 entry):
  - load_en = !wb_valid_o | wb_ready_i.
  - ic_rsp_ready_o = load_en. dc_rsp_ready_o = load_en & !ic_rsp_valid_i; icacop has priority when both valid.
  - Latency: accepted response visible on wb_* next cycle.
  - ICache load: we=0, wdata=0, pdest=0, icacop=1.
  - DCache load: we=dc_rsp_we_i, data passed through, icacop=0.
  - wb_valid_o clears on wb_ready_i when nothing new is loaded. Full throughput: one wb per cycle when wb_ready_i stays 1.
- flush_i (sync, highest priority): next cycle FIFO empty, count_o=0, wb_valid_o=0.
  - Same-cycle enqueue is dropped.
  - Same-cycle dequeue handshakes still count on the cache side; caches drop them on their own flush.
  - Response ready outputs are forced 0 during flush.
- Reset mid-transfer: all state cleared immediately; no partial entries.

Test Plan:
- Reset then enqueue load src0=0x1000, imm=0x24, dc_req_ready_i=1 -> dc_req_valid_o=1 with vaddr 0x1024 next cycle; count_o returns to 0.
- Enqueue 4 stores with dc_req_ready_i=0 -> count_o=4, exe_ready_o=0; 5th exe_valid_i is ignored. Release ready -> 4 requests issue in ROB order 0..3, and wrap-around enqueue resumes.
- Cacop code=0b01000, src0=0x2000, imm=3 while dc_busy_i=1 -> ic_req_valid_o stays 0. When dc_busy_i drops -> ic_req_vaddr_o=0x200C, ic_req_mode_o=1, and no dc request is issued.
- dc_rsp_valid_i and ic_rsp_valid_i high in the same cycle (rob 5, rob 9) -> wb rob 9 with icacop=1 first, then rob 5 with dc rdata. dc_rsp_ready_o=0 in the first cycle.
- wb_ready_i=0 with a wb pending, then a new dc response arrives -> dc_rsp_ready_o=0 and the wb output is held stable. When wb_ready_i=1 -> back-to-back wb.
- flush_i with 3 entries queued and a wb pending -> next cycle count_o=0, wb_valid_o=0, both req valids 0.
